banked_dat_mem: RTL and testbench
=================================

Name: banked_dat_mem

Overview:
- Parametrised successor to the 8-bit, 256-word banked data memory.
- Width, depth and bank size are generics. Bank-relative addressing wraps explicitly within the array.
- A hardware clear engine zeroes the whole array after reset, or one bank / all banks on request.
- Sits on the datapath's load/store/push port. The read path stays combinational.

Parameters:
DW, 8, data word width in bits
AW, 8, physical address width; DEPTH = 2**AW words
BANK_AW, 5, bank offset width; BANK_WORDS = 2**BANK_AW; NBANKS = 2**(AW-BANK_AW)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
dat_in  in  DW  write data
wr_en  in  1  write enable
addr  in  AW  address pointer, offset from bank base
bank_num  in  AW-BANK_AW  bank select
clr_req  in  1  single-cycle clear request
clr_all  in  1  qualifies clr_req: 1 = whole array, 0 = bank_num only
dat_out  out  DW  combinational read data
busy  out  1  clear engine active
addr_oob  out  1  combinational: addr >= BANK_WORDS (access crosses bank)
wr_err  out  1  registered one-cycle pulse: a requested write was discarded

Behaviour:
- Physical address pa = (addr + bank_num*BANK_WORDS) mod DEPTH, truncated to AW bits. Out-of-bank accesses are flagged via addr_oob but still performed.
- Read: dat_out = mem[pa] combinationally when busy=0. dat_out = 0 while busy=1.
- Read-during-write to the same pa: dat_out shows the old value until the edge, then the new value.
- Write: mem[pa] <= dat_in on a rising edge with wr_en=1, busy=0 and clr_req=0.
- Internal state: IDLE, CLR. Registers: clear counter cnt (AW bits), clear limit lim, base address.
- Reset (rst_n=0 at an edge):
  - state=CLR, cnt=0, base=0, lim=DEPTH-1.
  - Outputs: busy=1, wr_err=0, dat_out=0.
  - No memory writes occur while rst_n=0.
- CLR, each edge with rst_n=1:
  - mem[base+cnt] <= 0, then cnt <= cnt+1.
  - If cnt==lim, go to IDLE next.
  - After reset release, edges 1..DEPTH zero addresses 0..DEPTH-1. busy is 0 after edge DEPTH.
- IDLE with clr_req=1 at an edge:
  - clr_all=1: base=0, lim=DEPTH-1.
  - clr_all=0: base=bank_num*BANK_WORDS (latched), lim=BANK_WORDS-1.
  - cnt=0, state=CLR; busy rises after that edge.
  - The first zeroing write happens on the following edge.
  - A bank clear takes BANK_WORDS cycles of busy; a full clear takes DEPTH.
- clr_req while busy: ignored. A clear is never queued or restarted.
- Simultaneous wr_en and clr_req in IDLE: the clear wins, the write is discarded, and wr_err=1 for the next cycle.
- wr_en=1 while busy: the write is discarded and wr_err=1 for the next cycle.
- wr_err is otherwise 0; it is re-evaluated every edge.
- Reset asserted mid-clear or mid-operation: the engine aborts and restarts a full-array clear from address 0 on release. Any pending wr_err is cleared.
- Bank-clear wrap: base+cnt never exceeds DEPTH-1 because base is bank-aligned.
- Memory contents are not otherwise reset; only the clear engine zeroes them.

Test Plan:
- Reset clear: hold rst_n=0 for 3 cycles, release. Required: busy=1 for exactly 256 edges then 0; reads of addr 0, 127, 255 in bank 0 return 8'h00.
- Banked addressing and wrap: write 8'hA5 at bank 3/addr 2 (pa 98) and read it back 8'hA5, addr_oob=0. Write 8'h3C at bank 7/addr 40. Required: pa 8'h08 (wraps), addr_oob=1; bank 0/addr 8 reads 8'h3C.
- Bank clear isolation: fill banks 2 and 3 with 8'hFF, pulse clr_req with clr_all=0, bank_num=2. Required: busy high 32 cycles; bank 2 reads 0; bank 3 still reads 8'hFF.
- Write during busy: during a bank clear, wr_en=1 to bank 5/addr 0 with 8'h77. Required: wr_err pulses 1 cycle; after busy falls, bank 5/addr 0 is unchanged.
- Simultaneous clr_req and wr_en in IDLE (bank 1, data 8'h11): required clear starts, write dropped, wr_err=1 next cycle, bank 1 reads 0 after clear.
- Reset mid-clear: assert rst_n=0 at clear cycle 10 of a full clear. Required: busy stays 1, and 256 further cycles elapse after release before busy=0.

Source files
------------

// File: rtl/banked_dat_mem.sv
// Banked data memory with a combinational read port, bank-relative addressing
// and a clear engine that zeroes the whole array or a single bank.
module banked_dat_mem #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int BANK_AW = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         dat_in,
  input  logic                  wr_en,
  input  logic [AW-1:0]         addr,
  input  logic [AW-BANK_AW-1:0] bank_num,
  input  logic                  clr_req,
  input  logic                  clr_all,
  output logic [DW-1:0]         dat_out,
  output logic                  busy,
  output logic                  addr_oob,
  output logic                  wr_err
);

  localparam int DEPTH      = 1 << AW;
  localparam int BANK_WORDS = 1 << BANK_AW;
  localparam logic [AW-1:0] LIM_ALL  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LIM_BANK = AW'(BANK_WORDS - 1);

  typedef enum logic {IDLE, CLR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] lim_q, lim_d;
  logic [AW-1:0] base_q, base_d;
  logic          wr_err_q, wr_err_d;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] bank_base;
  logic [AW-1:0] pa;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // The AW-bit sum wraps, so accesses past the last bank land back at address 0.
  assign bank_base = {bank_num, {BANK_AW{1'b0}}};
  assign pa        = addr + bank_base;
  assign addr_oob  = |addr[AW-1:BANK_AW];
  assign busy      = (state_q == CLR);
  assign wr_err    = wr_err_q;
  assign dat_out   = busy ? '0 : mem[pa];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    base_d    = base_q;
    wr_err_d  = wr_en & (busy | clr_req);
    mem_we    = 1'b0;
    mem_waddr = pa;
    mem_wdata = dat_in;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLR;
          cnt_d   = '0;
          base_d  = clr_all ? '0 : bank_base;
          lim_d   = clr_all ? LIM_ALL : LIM_BANK;
        end else if (wr_en) begin
          mem_we = 1'b1;
        end
      end
      CLR: begin
        // base is bank-aligned, so base+cnt never carries out of the array
        mem_we    = 1'b1;
        mem_waddr = base_q + cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == lim_q) state_d = IDLE;
      end
      default: state_d = CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CLR;
      cnt_q    <= '0;
      base_q   <= '0;
      lim_q    <= LIM_ALL;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      lim_q    <= lim_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Array contents have no reset; only the clear engine zeroes them.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_banked_dat_mem.sv
// Directed bench for banked_dat_mem with a per-cycle compare against a
// behavioural model of the memory and its clear engine.
module tb_banked_dat_mem;
  localparam int DW = 8, AW = 8, BANK_AW = 5;
  localparam int DEPTH = 256, BW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] dat_in;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic [AW-BANK_AW-1:0] bank_num;
  logic          clr_req;
  logic          clr_all;
  logic [DW-1:0] dat_out;
  logic          busy;
  logic          addr_oob;
  logic          wr_err;

  int errors = 0;
  int checks = 0;

  banked_dat_mem #(.DW(DW), .AW(AW), .BANK_AW(BANK_AW)) dut (
    .clk(clk), .rst_n(rst_n), .dat_in(dat_in), .wr_en(wr_en), .addr(addr),
    .bank_num(bank_num), .clr_req(clr_req), .clr_all(clr_all),
    .dat_out(dat_out), .busy(busy), .addr_oob(addr_oob), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a clear is a run of "left" zeroing cycles walking up from ptr.
  logic [7:0] m_mem [DEPTH];
  int   m_left = DEPTH;
  int   m_ptr  = 0;
  logic m_err  = 1'b0;
  bit   chk_en = 1'b0;

  function automatic int m_pa(input logic [AW-1:0] a, input logic [AW-BANK_AW-1:0] b);
    return (int'(a) + int'(b) * BW) % DEPTH;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = DEPTH;
      m_ptr  = 0;
      m_err  = 1'b0;
    end else if (m_left > 0) begin
      m_mem[m_ptr] = 8'h00;
      m_ptr++;
      m_left--;
      m_err = wr_en;
    end else begin
      m_err = wr_en && clr_req;
      if (clr_req) begin
        m_ptr  = clr_all ? 0 : int'(bank_num) * BW;
        m_left = clr_all ? DEPTH : BW;
      end else if (wr_en) begin
        m_mem[m_pa(addr, bank_num)] = dat_in;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_left > 0);
      chk("wr_err", wr_err, m_err);
      chk("addr_oob", addr_oob, addr >= BW);
      chk("dat_out", dat_out, (m_left > 0) ? 8'h00 : m_mem[m_pa(addr, bank_num)]);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n, input int maxc);
    n = 0;
    while (busy === 1'b1 && n < maxc) begin
      step;
      n++;
    end
  endtask

  task automatic wr(input logic [2:0] b, input logic [7:0] a, input logic [7:0] d);
    bank_num = b; addr = a; dat_in = d; wr_en = 1'b1;
    step;
    wr_en = 1'b0;
  endtask

  task automatic rd(input string name, input logic [2:0] b, input logic [7:0] a,
                    input logic [7:0] exp_d, input logic exp_oob);
    bank_num = b; addr = a;
    #1;
    chk(name, dat_out, exp_d);
    chk({name, "_oob"}, addr_oob, exp_oob);
    step;
  endtask

  task automatic start_clear(input logic all, input logic [2:0] b);
    clr_all = all; bank_num = b; clr_req = 1'b1;
    step;
    clr_req = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; dat_in = '0; wr_en = 1'b0; addr = '0; bank_num = '0;
    clr_req = 1'b0; clr_all = 1'b0;

    repeat (3) step;
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_dat_out", dat_out, 8'h00);
    rst_n = 1'b1;
    wait_idle(n, 400);
    chk("reset_clear_len", n, 256);
    rd("rd_a0", 3'd0, 8'd0, 8'h00, 1'b0);
    rd("rd_a127", 3'd0, 8'd127, 8'h00, 1'b1);
    rd("rd_a255", 3'd0, 8'd255, 8'h00, 1'b1);

    wr(3'd3, 8'd2, 8'hA5);
    rd("rd_b3a2", 3'd3, 8'd2, 8'hA5, 1'b0);
    rd("rd_pa98", 3'd0, 8'd98, 8'hA5, 1'b1);
    wr(3'd7, 8'd40, 8'h3C);
    rd("rd_b7a40", 3'd7, 8'd40, 8'h3C, 1'b1);
    rd("rd_wrap_pa8", 3'd0, 8'd8, 8'h3C, 1'b0);

    for (int i = 0; i < 64; i++) wr(3'd2, 8'(i), 8'hFF);
    start_clear(1'b0, 3'd2);
    chk("bank_clr_busy", busy, 1'b1);
    wait_idle(n, 100);
    chk("bank_clr_len", n, 32);
    rd("b2_first", 3'd2, 8'd0, 8'h00, 1'b0);
    rd("b2_last", 3'd2, 8'd31, 8'h00, 1'b0);
    rd("b3_first", 3'd3, 8'd0, 8'hFF, 1'b0);
    rd("b3_last", 3'd3, 8'd31, 8'hFF, 1'b0);

    wr(3'd5, 8'd0, 8'h5A);
    start_clear(1'b0, 3'd4);
    wr(3'd5, 8'd0, 8'h77);
    chk("wr_busy_err", wr_err, 1'b1);
    step;
    chk("wr_busy_err_end", wr_err, 1'b0);
    wait_idle(n, 100);
    chk("wr_busy_clr_len", n, 30);
    rd("b5_kept", 3'd5, 8'd0, 8'h5A, 1'b0);
    rd("b4_cleared", 3'd4, 8'd0, 8'h00, 1'b0);

    wr(3'd1, 8'd3, 8'h22);
    rd("b1_pre", 3'd1, 8'd3, 8'h22, 1'b0);
    bank_num = 3'd1; addr = 8'd3; dat_in = 8'h11; wr_en = 1'b1;
    clr_all = 1'b0; clr_req = 1'b1;
    step;
    wr_en = 1'b0; clr_req = 1'b0;
    chk("simul_wr_err", wr_err, 1'b1);
    chk("simul_busy", busy, 1'b1);
    wait_idle(n, 100);
    chk("simul_clr_len", n, 32);
    rd("b1_cleared", 3'd1, 8'd3, 8'h00, 1'b0);

    wr(3'd6, 8'd9, 8'h99);
    start_clear(1'b1, 3'd0);
    repeat (10) step;
    wr_en = 1'b1; rst_n = 1'b0;
    step;
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_wr_err", wr_err, 1'b0);
    wr_en = 1'b0; rst_n = 1'b1;
    wait_idle(n, 400);
    chk("midrst_clr_len", n, 256);
    rd("b6_cleared", 3'd6, 8'd9, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
